// File: rtl/fp_acc.sv
// Multi-cycle FP32 accumulator: sums a valid/ready stream of products and emits the sum on in_last.
// Optional FP_ACC_SAT_EN: exponent overflow saturates to max finite and sticks until the result handshake.
module fp_acc #(
  parameter int GUARD_BITS    = 3,
  parameter bit CLEAR_ON_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
  localparam int         W  = 24 + GUARD_BITS;
  localparam logic [7:0] W8 = 8'(W);
`ifdef FP_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic [31:0]  acc, op;
  logic         last_q, ovf;
  logic [W-1:0] ma, mb;
  logic [W:0]   man;
  logic [9:0]   ex;
  logic         sa, sb, sr;

  // Alignment: acc is operand a, the captured input is operand b.
  logic [7:0]   ea, eb, dexp;
  logic         a_zero, b_zero, a_big;
  logic [W-1:0] m_a, m_b, m_small, m_shf;
  assign ea     = acc[30:23];
  assign eb     = op[30:23];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_big  = (ea >= eb);
  assign m_a    = {1'b1, acc[22:0], {GUARD_BITS{1'b0}}};
  assign m_b    = {1'b1, op[22:0], {GUARD_BITS{1'b0}}};

  always_comb begin
    dexp    = a_big ? (ea - eb) : (eb - ea);
    m_small = a_big ? m_b : m_a;
    m_shf   = '0;
    if (dexp > W8) begin
      m_shf[0] = 1'b1;
    end else begin
      m_shf    = m_small >> dexp;
      m_shf[0] = m_shf[0] | (|(m_small & ~({W{1'b1}} << dexp)));
    end
  end

  logic [W:0] sum;
  logic       s_sum;
  always_comb begin
    sum   = '0;
    s_sum = sa;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
    end else if (ma >= mb) begin
      sum = {1'b0, ma - mb};
    end else begin
      sum   = {1'b0, mb - ma};
      s_sum = sb;
    end
  end

  // Round-to-nearest-even on the normalised mantissa; G/R/S live in the low GUARD_BITS.
  logic        rup, ovf_now;
  logic [24:0] sig;
  logic [9:0]  ex_r;
  logic [31:0] rres;
  always_comb begin
    rup  = man[GUARD_BITS-1] & ((|man[GUARD_BITS-2:0]) | man[GUARD_BITS]);
    sig  = {1'b0, man[W-1:GUARD_BITS]} + {24'd0, rup};
    ex_r = ex;
    if (sig[24]) begin
      sig  = sig >> 1;
      ex_r = ex + 10'd1;
    end
    ovf_now = (ex_r >= 10'd255);
    if (!ovf_now)  rres = {sr, ex_r[7:0], sig[22:0]};
    else if (SAT)  rres = {sr, 8'hFE, 23'h7FFFFF};
    else           rres = {sr, 8'hFF, 23'h0};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = ALIGN;
      ALIGN: state_nx = (ovf || a_zero || b_zero) ? DONE : ADD;
      ADD:   state_nx = (sum == '0) ? DONE : NORM;
      NORM:  if (man[W] || man[W-1]) state_nx = ROUND;
             else if (ex == 10'd1)   state_nx = DONE;
      ROUND: state_nx = DONE;
      DONE:  if (!last_q || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0; op <= '0; last_q <= 1'b0; ovf <= 1'b0;
      ma <= '0; mb <= '0; man <= '0; ex <= '0;
      sa <= 1'b0; sb <= 1'b0; sr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op     <= in_data;
          last_q <= in_last;
        end
        ALIGN: begin
          // A saturated sequence keeps acc untouched until the result is taken.
          if (ovf) ;
          else if (a_zero) acc <= b_zero ? 32'h0 : op;
          else if (!b_zero) begin
            ma <= a_big ? m_a : m_shf;
            mb <= a_big ? m_shf : m_b;
            ex <= {2'b00, a_big ? ea : eb};
            sa <= acc[31];
            sb <= op[31];
          end
        end
        ADD: begin
          man <= sum;
          sr  <= s_sum;
          if (sum == '0) acc <= 32'h0;
        end
        NORM: begin
          if (man[W]) begin
            man <= {1'b0, man[W:2], man[1] | man[0]};
            ex  <= ex + 10'd1;
          end else if (!man[W-1]) begin
            man <= {man[W-1:0], 1'b0};
            ex  <= ex - 10'd1;
            if (ex == 10'd1) acc <= 32'h0;
          end
        end
        ROUND: begin
          acc <= rres;
          if (SAT && ovf_now) ovf <= 1'b1;
        end
        DONE: if (last_q && out_ready) begin
          if (CLEAR_ON_LAST) acc <= 32'h0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE) && last_q;
  assign out_data  = acc;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_fp_acc.sv
// Directed bench for fp_acc: a driver queues expected sums, a forked monitor checks each result handshake.
module tb_fp_acc;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = 32'h0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  int          checks = 0, failures = 0;
  logic [31:0] sb_q[$];

  fp_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge after the accepting posedge (DUT then in ALIGN).
  task automatic send(input logic [31:0] d, input logic l, input logic push, input logic [31:0] e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready never rose for %h", d);
    end
    in_valid = 1'b1; in_data = d; in_last = l;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wait_out_timeout: out_valid never rose");
    end
  endtask

  task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int n;
    send(a, 1'b0, 1'b0, 32'h0);
    send(b, 1'b1, 1'b1, e);
    wait_out(n);
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got %h expected no output", out_data);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e);
        end
      end
    end
  endtask

  task automatic watchdog();
    #200000;
    checks++; failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    int n;
    logic [31:0] sat_exp;
    fork
      monitor();
      watchdog();
    join_none

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1.0 + 2.0, with latency from accept to out_valid
    send(32'h3F800000, 1'b0, 1'b0, 32'h0);
    send(32'h40000000, 1'b1, 1'b1, 32'h40400000);
    check("busy_align", {31'd0, busy}, 32'd1);
    check("in_ready_align", {31'd0, in_ready}, 32'd0);
    wait_out(n);
    check("latency", n, 32'd4);

    pair(32'h3F800000, 32'hBF800000, 32'h00000000);
    pair(32'h3F800000, 32'h33800000, 32'h3F800000);
    pair(32'h3F800000, 32'h34400000, 32'h3F800002);
`ifdef FP_ACC_SAT_EN
    sat_exp = 32'h7F7FFFFF;
`else
    sat_exp = 32'h7F800000;
`endif
    pair(32'h7F7FFFFF, 32'h7F7FFFFF, sat_exp);
    pair(32'h40400000, 32'hBF800000, 32'h40000000);
    pair(32'h3F800000, 32'hC0000000, 32'hBF800000);
    pair(32'h3F800000, 32'h00000001, 32'h3F800000);
    pair(32'h3F800000, 32'hBF7FFFFF, 32'h33800000);

    // Backpressure at DONE
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h3F800000, 1'b0, 1'b0, 32'h0);
    send(32'h40000000, 1'b1, 1'b1, 32'h40400000);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_out_data", out_data, 32'h40400000);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    send(32'h40000000, 1'b1, 1'b1, 32'h40000000);
    wait_out(n);

    // Reset in the middle of NORM: nothing may come out
    send(32'h3F800000, 1'b0, 1'b0, 32'h0);
    send(32'hBF7FFFFF, 1'b1, 1'b0, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_acc", out_data, 32'h0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    send(32'h3F800000, 1'b1, 1'b1, 32'h3F800000);
    wait_out(n);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
